// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : y86_pkg
//  Brief    : Shared Y86-64 encodings: icodes, register-none marker, status
//             codes and the pipeline-control run-state enum.
//  Revision : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  // Register id meaning "no register"
  localparam logic [3:0] RNONE  = 4'hF;

  // Status codes
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  // Run-state of the pipeline controller
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } run_state_e;

  // Anything other than AOK stops normal execution
  function automatic logic is_exc(input logic [2:0] stat);
    return (stat != AOK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect
//  Brief    : Purely combinational hazard terms for the Y86-64 pipeline:
//             load/use, return in flight, mispredict, memory and write-back
//             exceptions.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_detect (
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] M_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       lu,
  output logic       rt,
  output logic       mp,
  output logic       mx,
  output logic       wx
);
  import y86_pkg::*;

  logic w_e_is_load;
  logic w_dst_used;

  // A load in E whose destination is read by the instruction in D
  always_comb begin
    w_e_is_load = (E_icode == MRMOVQ) || (E_icode == POPQ);
    w_dst_used  = (E_dstM != RNONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    lu          = w_e_is_load && w_dst_used;
    rt          = (D_icode == RET) || (E_icode == RET) || (M_icode == RET);
    mp          = (E_icode == JXX) && !e_Cnd;
    mx          = is_exc(m_stat);
    wx          = is_exc(W_stat);
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Brief    : Y86-64 pipeline control: stall/bubble generation for the F, D,
//             E, M and W registers, run/halted FSM and saturating
//             performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_bubble,
  output logic             set_cc,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] stl_cnt,
  output logic [CNT_W-1:0] mis_cnt
);
  import y86_pkg::*;

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic w_lu;
  logic w_rt;
  logic w_mp;
  logic w_mx;
  logic w_wx;
  logic w_retire;

  run_state_e       r_state;
  logic             r_halted;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_ret_cnt;
  logic [CNT_W-1:0] r_stl_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == c_CNT_MAX) ? v : v + 1'b1;
  endfunction

  hazard_detect u_hazard_detect (
    .D_icode (D_icode),
    .E_icode (E_icode),
    .M_icode (M_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_dstM  (E_dstM),
    .e_Cnd   (e_Cnd),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .lu      (w_lu),
    .rt      (w_rt),
    .mp      (w_mp),
    .mx      (w_mx),
    .wx      (w_wx)
  );

  // Zero-latency stall/bubble muxing: reset flush beats HALTED beats RUN
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    set_cc   = 1'b0;
    if (rst) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_bubble = 1'b1;
    end else if (r_state == ST_HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
    end else begin
      F_stall  = w_lu || w_rt;
      D_stall  = w_lu;
      // A load/use stall on D overrides the ret bubble; mispredict wins over both
      D_bubble = w_mp || (!w_lu && w_rt);
      E_bubble = w_mp || w_lu;
      M_bubble = w_mx || w_wx;
      W_stall  = w_wx;
      set_cc   = (E_icode == OPQ) && !w_mx && !w_wx;
    end
  end

  // An instruction retires when a valid non-nop leaves W with good status
  assign w_retire = (W_stat == AOK) && (W_icode != NOP) && !W_stall;

  // Run-state FSM: freeze on the first exception seen in W, exit only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_wx) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          r_state  <= ST_HALTED;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters, advancing only while running
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
      r_stl_cnt <= '0;
      r_mis_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_cyc_cnt <= sat_inc(r_cyc_cnt);
      if (w_retire) r_ret_cnt <= sat_inc(r_ret_cnt);
      if (w_lu)     r_stl_cnt <= sat_inc(r_stl_cnt);
      if (w_mp)     r_mis_cnt <= sat_inc(r_mis_cnt);
    end
  end

  assign halted  = r_halted;
  assign cyc_cnt = r_cyc_cnt;
  assign ret_cnt = r_ret_cnt;
  assign stl_cnt = r_stl_cnt;
  assign mis_cnt = r_mis_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Brief    : Self-checking bench for pipe_ctrl: directed scenarios followed
//             by randomized cycles against a rule-level reference model.
//             A second instance with 4-bit counters exercises saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D_icode, E_icode, M_icode, W_icode;
  logic [3:0] d_srcA, d_srcB, E_dstM;
  logic       e_Cnd;
  logic [2:0] m_stat, W_stat;

  logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, W_bubble;
  logic        set_cc, halted;
  logic [31:0] cyc_cnt, ret_cnt, stl_cnt, mis_cnt;

  logic        F_stall_4, D_stall_4, W_stall_4, D_bubble_4, E_bubble_4, M_bubble_4, W_bubble_4;
  logic        set_cc_4, halted_4;
  logic [3:0]  cyc_cnt_4, ret_cnt_4, stl_cnt_4, mis_cnt_4;

  int tests = 0;
  int fails = 0;

  // Reference model state: a halted flag and raw event counts while running
  bit     m_halted;
  longint n_cyc, n_ret, n_stl, n_mis;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_bubble(W_bubble),
    .set_cc(set_cc), .halted(halted),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stl_cnt(stl_cnt), .mis_cnt(mis_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall_4), .D_stall(D_stall_4), .W_stall(W_stall_4),
    .D_bubble(D_bubble_4), .E_bubble(E_bubble_4), .M_bubble(M_bubble_4), .W_bubble(W_bubble_4),
    .set_cc(set_cc_4), .halted(halted_4),
    .cyc_cnt(cyc_cnt_4), .ret_cnt(ret_cnt_4), .stl_cnt(stl_cnt_4), .mis_cnt(mis_cnt_4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat4(input longint n);
    return (n > 15) ? 15 : n;
  endfunction

  // Hazard terms straight from the control rules
  function automatic bit f_lu();
    return ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  endfunction
  function automatic bit f_rt();
    return (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
  endfunction
  function automatic bit f_mp();
    return (E_icode == 4'h7) && !e_Cnd;
  endfunction

  // Compare combinational outputs of both instances with the model
  task automatic check_comb();
    bit lu, rt, mp, mx, wx;
    bit eF, eD, eW, eDb, eEb, eMb, eWb, eCC;
    lu = f_lu(); rt = f_rt(); mp = f_mp();
    mx = (m_stat != 3'd1); wx = (W_stat != 3'd1);
    if (rst) begin
      {eF, eD, eW} = 3'b000; {eDb, eEb, eMb, eWb} = 4'b1111; eCC = 1'b0;
    end else if (m_halted) begin
      {eF, eD, eW} = 3'b111; {eDb, eEb, eMb, eWb} = 4'b0000; eCC = 1'b0;
    end else begin
      eF = lu || rt; eD = lu; eW = wx;
      eDb = mp || (rt && !lu); eEb = mp || lu; eMb = mx || wx; eWb = 1'b0;
      eCC = (E_icode == 4'h6) && !mx && !wx;
    end
    chk("F_stall",  F_stall,  eF);  chk("D_stall",  D_stall,  eD);
    chk("W_stall",  W_stall,  eW);  chk("D_bubble", D_bubble, eDb);
    chk("E_bubble", E_bubble, eEb); chk("M_bubble", M_bubble, eMb);
    chk("W_bubble", W_bubble, eWb); chk("set_cc",   set_cc,   eCC);
    chk("sat_ctl",  {F_stall_4, D_stall_4, W_stall_4, D_bubble_4, E_bubble_4,
                     M_bubble_4, W_bubble_4, set_cc_4},
                    {eF, eD, eW, eDb, eEb, eMb, eWb, eCC});
  endtask

  // Advance the model by one rising edge using the inputs presently driven
  task automatic model_edge();
    if (rst) begin
      m_halted = 1'b0;
      n_cyc = 0; n_ret = 0; n_stl = 0; n_mis = 0;
    end else if (!m_halted) begin
      n_cyc++;
      if (W_stat == 3'd1 && W_icode != 4'h1) n_ret++;
      if (f_lu()) n_stl++;
      if (f_mp()) n_mis++;
      if (W_stat != 3'd1) m_halted = 1'b1;
    end
  endtask

  task automatic check_regs();
    chk("halted",  halted,  m_halted);
    chk("cyc_cnt", cyc_cnt, n_cyc);
    chk("ret_cnt", ret_cnt, n_ret);
    chk("stl_cnt", stl_cnt, n_stl);
    chk("mis_cnt", mis_cnt, n_mis);
    chk("halted4", halted_4, m_halted);
    chk("cyc4", cyc_cnt_4, sat4(n_cyc));
    chk("ret4", ret_cnt_4, sat4(n_ret));
    chk("stl4", stl_cnt_4, sat4(n_stl));
    chk("mis4", mis_cnt_4, sat4(n_mis));
  endtask

  // One clock: check comb outputs, take the edge, check registered outputs
  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic quiet();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
    m_stat = 3'd1; W_stat = 3'd1;
  endtask

  initial begin
    m_halted = 1'b0;
    n_cyc = 0; n_ret = 0; n_stl = 0; n_mis = 0;
    rst = 1'b1;
    quiet();

    // Reset flush
    #1;
    chk("rst_flush", {D_bubble, E_bubble, M_bubble, W_bubble, F_stall, D_stall, W_stall},
                     7'b1111_000);
    step();
    rst = 1'b0;

    // Load/use
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1;
    chk("lu_ctl", {F_stall, D_stall, E_bubble}, 3'b111);
    step();
    chk("lu_stl_cnt", stl_cnt, 32'd1);
    quiet();
    #1;
    chk("lu_clear", {F_stall, D_stall, E_bubble}, 3'b000);
    step();

    // Ret travelling D -> E -> M
    D_icode = 4'h9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ret_ctl", {F_stall, D_bubble}, 2'b11);
      step();
      D_icode = 4'h1; E_icode = (i == 0) ? 4'h9 : 4'h1; M_icode = (i == 1) ? 4'h9 : 4'h1;
    end
    #1;
    chk("ret_done", {F_stall, D_bubble}, 2'b00);
    step();

    // Mispredict, then mispredict with ret in D
    E_icode = 4'h7; e_Cnd = 1'b0;
    #1;
    chk("mp_ctl", {D_bubble, E_bubble, F_stall}, 3'b110);
    step();
    chk("mp_cnt", mis_cnt, 32'd1);
    D_icode = 4'h9;
    #1;
    chk("mp_rt_ctl", {D_bubble, F_stall}, 2'b11);
    step();
    quiet();

    // Retire a few instructions
    W_icode = 4'h6;
    step(); step();
    quiet();

    // Exception in memory, then in W, then halted
    m_stat = 3'd3; E_icode = 4'h6;
    #1;
    chk("mx_ctl", {M_bubble, set_cc}, 2'b10);
    step();
    quiet();
    W_stat = 3'd3;
    #1;
    chk("wx_stall", W_stall, 1'b1);
    step();
    chk("halted_up", halted, 1'b1);
    quiet();
    E_icode = 4'h5; E_dstM = 4'h2; d_srcB = 4'h2;
    step(); step();
    chk("halt_stalls", {F_stall, D_stall, W_stall}, 3'b111);

    // Reset while halted
    rst = 1'b1;
    #1;
    chk("rst_halt_flush", {D_bubble, E_bubble, M_bubble, W_bubble}, 4'b1111);
    step();
    chk("rst_halt_clear", {halted, cyc_cnt}, 33'd0);
    rst = 1'b0;
    quiet();

    // Saturation of the 4-bit instance
    for (int i = 0; i < 20; i++) step();
    chk("sat_cyc4", cyc_cnt_4, 4'd15);

    // Randomized rounds, each opened with a reset
    for (int r = 0; r < 6; r++) begin
      rst = 1'b1;
      quiet();
      step();
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
        D_icode = 4'($urandom_range(0, 11));
        E_icode = ($urandom_range(0, 9) < 3) ? (($urandom_range(0, 1) == 0) ? 4'h5 : 4'hB)
                                              : 4'($urandom_range(0, 11));
        M_icode = 4'($urandom_range(0, 11));
        W_icode = 4'($urandom_range(0, 11));
        d_srcA  = 4'($urandom_range(0, 15));
        d_srcB  = 4'($urandom_range(0, 15));
        E_dstM  = ($urandom_range(0, 2) == 0) ? d_srcA : 4'($urandom_range(0, 15));
        e_Cnd   = 1'($urandom_range(0, 1));
        m_stat  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
        W_stat  = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
        if (r == 5 && c == 2) rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
